// File: rtl/san_irq_pkg.sv
// ---------------------------------------------------------------------------
// san_irq_pkg : register map, limits and encodings for the san IRQ controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package san_irq_pkg;

  localparam int NUM_SRC_MAX = 31;

  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_ENA   = 3'd1;
  localparam logic [2:0] REG_TYPE  = 3'd2;
  localparam logic [2:0] REG_MPEND = 3'd3;
  localparam logic [2:0] REG_OVF   = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;
  localparam logic [2:0] REG_ID    = 3'd6;

  localparam logic TYPE_EDGE  = 1'b1;
  localparam logic TYPE_LEVEL = 1'b0;

  // Scan from the top down so the lowest set index is the one left in idx.
  function automatic logic [4:0] lowest_set(input logic [NUM_SRC_MAX-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_SRC_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/san_irq_sync_edge.sv
// ---------------------------------------------------------------------------
// san_irq_sync_edge : per-source input synchronizer with rising-edge detector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module san_irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic level_o,
  output logic rise_o
);

  logic w_level;
  logic hist_q;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= irq_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign w_level = sync_q[SYNC_STAGES-1];
  end else begin : g_nosync
    assign w_level = irq_i;
  end

  // hist resets low, so a line held high through reset yields one rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= 1'b0;
    else       hist_q <= w_level;
  end

  assign level_o = w_level;
  assign rise_o  = w_level & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/san_irq_ctrl.sv
// ---------------------------------------------------------------------------
// san_irq_ctrl : IRQ pending/mask/overflow register file with aggregated IRQ_OUT
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module san_irq_ctrl
  import san_irq_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic               slv_reg_wren,
  input  logic [2:0]         axi_awaddr,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic               slv_reg_rden,
  input  logic [2:0]         axi_araddr,
  output logic [31:0]        reg_data_out,
  output logic               IRQ_OUT
);

  logic [NUM_SRC-1:0] level, rise;
  logic [NUM_SRC-1:0] pend_q, pend_d, ovf_q, ovf_d;
  logic [NUM_SRC-1:0] ena_q, type_q;
  logic               gie_q, irq_q;
  logic [31:0]        rdata_q, rdata_d;

  logic [NUM_SRC-1:0] wdata_src, pend_w1c, ovf_w1c, pend_set, ovf_set, mpend;
  logic [4:0]         id_idx;
  logic               w_unused_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    san_irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i  (S_AXI_ACLK),
      .rst_i  (S_AXI_ARESET),
      .irq_i  (IRQ_IN[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  assign wdata_src      = S_AXI_WDATA[NUM_SRC-1:0];
  assign w_unused_wdata = &{1'b0, S_AXI_WDATA};
  assign pend_w1c = (slv_reg_wren && axi_awaddr == REG_PEND) ? wdata_src : '0;
  assign ovf_w1c  = (slv_reg_wren && axi_awaddr == REG_OVF)  ? wdata_src : '0;

  // Sets win over W1C; OVF only flags an edge on a bit not being acked this cycle.
  always_comb begin
    pend_set = '0;
    ovf_set  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_set[i] = (type_q[i] == TYPE_EDGE) ? rise[i] : level[i];
      ovf_set[i]  = (type_q[i] == TYPE_EDGE) & rise[i] & pend_q[i] & ~pend_w1c[i];
    end
    pend_d = (pend_q & ~pend_w1c) | pend_set;
    ovf_d  = (ovf_q  & ~ovf_w1c)  | ovf_set;
  end

  assign mpend  = pend_q & ena_q;
  assign id_idx = lowest_set(NUM_SRC_MAX'(mpend));

  always_comb begin
    rdata_d = rdata_q;
    if (slv_reg_rden) begin
      case (axi_araddr)
        REG_PEND:  rdata_d = 32'(pend_q);
        REG_ENA:   rdata_d = 32'(ena_q);
        REG_TYPE:  rdata_d = 32'(type_q);
        REG_MPEND: rdata_d = 32'(mpend);
        REG_OVF:   rdata_d = 32'(ovf_q);
        REG_CTRL:  rdata_d = {31'd0, gie_q};
        REG_ID:    rdata_d = {|mpend, 26'd0, id_idx};
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      pend_q  <= '0;
      ovf_q   <= '0;
      ena_q   <= '0;
      type_q  <= '0;
      gie_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      // Uses the already-registered PEND, giving one extra edge after the set.
      irq_q   <= gie_q & |(pend_q & ena_q);
      if (slv_reg_wren) begin
        case (axi_awaddr)
          REG_ENA:  ena_q  <= wdata_src;
          REG_TYPE: type_q <= wdata_src;
          REG_CTRL: gie_q  <= S_AXI_WDATA[0];
          default:  ;
        endcase
      end
    end
  end

  assign reg_data_out = rdata_q;
  assign IRQ_OUT      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_san_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_san_irq_ctrl : directed self-checking bench for san_irq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_san_irq_ctrl;

  localparam int NUM_SRC = 8;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irq_in;
  logic               wren;
  logic [2:0]         awaddr;
  logic [31:0]        wdata;
  logic               rden;
  logic [2:0]         araddr;
  logic [31:0]        rdata;
  logic               irq_out;
  logic [31:0]        d;

  int n_chk = 0;
  int n_err = 0;

  san_irq_ctrl #(
    .NUM_SRC    (NUM_SRC),
    .SYNC_STAGES(2)
  ) u_dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .IRQ_IN      (irq_in),
    .slv_reg_wren(wren),
    .axi_awaddr  (awaddr),
    .S_AXI_WDATA (wdata),
    .slv_reg_rden(rden),
    .axi_araddr  (araddr),
    .reg_data_out(rdata),
    .IRQ_OUT     (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    wren = 1'b1; awaddr = a; wdata = v;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    rden = 1'b1; araddr = a;
    @(negedge clk);
    rden = 1'b0;
    v = rdata;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    @(negedge clk);
    irq_in = irq_in | m;
    @(negedge clk);
    irq_in = irq_in & ~m;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; wren = 1'b0; awaddr = '0; wdata = '0;
    rden = 1'b0; araddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", 32'(irq_out), 32'h0);
    rst = 1'b0;
    rd(3'd0, d); chk("rst_pend", d, 32'h0);
    rd(3'd5, d); chk("rst_ctrl", d, 32'h0);

    // 1: edge capture and IRQ_OUT latency
    wr(3'd2, 32'hFF); wr(3'd1, 32'h01); wr(3'd5, 32'h1);
    pulse(8'h01);
    repeat (2) @(negedge clk);
    chk("edge_irq_e3", 32'(irq_out), 32'h0);
    @(negedge clk);
    chk("edge_irq_e4", 32'(irq_out), 32'h1);
    rd(3'd0, d); chk("edge_pend", d, 32'h01);
    rd(3'd6, d); chk("edge_id", d, 32'h80000000);
    rd(3'd3, d); chk("edge_mpend", d, 32'h01);

    // 2: acknowledge, then ack colliding with a new rise
    wr(3'd0, 32'h01);
    chk("ack_irq_w", 32'(irq_out), 32'h1);
    @(negedge clk);
    chk("ack_irq_w1", 32'(irq_out), 32'h0);
    rd(3'd0, d); chk("ack_pend", d, 32'h0);
    pulse(8'h01);
    repeat (4) @(negedge clk);
    rd(3'd0, d); chk("ack_repend", d, 32'h01);
    pulse(8'h01);
    @(negedge clk);
    wren = 1'b1; awaddr = 3'd0; wdata = 32'h01;
    @(negedge clk);
    wren = 1'b0;
    rd(3'd0, d); chk("ack_setwins", d, 32'h01);
    rd(3'd4, d); chk("ack_noovf", d, 32'h0);
    wr(3'd0, 32'h01);
    rd(3'd0, d); chk("ack_clr", d, 32'h0);

    // 3: level mode
    wr(3'd2, 32'h0); wr(3'd1, 32'h04);
    irq_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    wr(3'd0, 32'h04);
    rd(3'd0, d); chk("lvl_hold", d, 32'h04);
    chk("lvl_irq", 32'(irq_out), 32'h1);
    irq_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    wr(3'd0, 32'h04);
    rd(3'd0, d); chk("lvl_clr", d, 32'h0);
    chk("lvl_irq_low", 32'(irq_out), 32'h0);

    // 4: mask and priority
    wr(3'd2, 32'hFF); wr(3'd1, 32'h20);
    pulse(8'h28);
    repeat (4) @(negedge clk);
    rd(3'd3, d); chk("pri_mpend", d, 32'h20);
    rd(3'd6, d); chk("pri_id5", d, 32'h80000005);
    chk("pri_irq", 32'(irq_out), 32'h1);
    wr(3'd1, 32'h28);
    rd(3'd6, d); chk("pri_id3", d, 32'h80000003);
    wr(3'd5, 32'h0);
    @(negedge clk);
    chk("pri_gie_off", 32'(irq_out), 32'h0);
    rd(3'd0, d); chk("pri_pend", d, 32'h28);
    wr(3'd0, 32'h28);
    rd(3'd0, d); chk("pri_clr", d, 32'h0);

    // 5: overflow
    pulse(8'h02);
    repeat (4) @(negedge clk);
    pulse(8'h02);
    repeat (4) @(negedge clk);
    rd(3'd4, d); chk("ovf_set", d, 32'h02);
    rd(3'd6, d); chk("ovf_id_none", d, 32'h0);
    wr(3'd4, 32'h02);
    rd(3'd4, d); chk("ovf_clr", d, 32'h0);
    rd(3'd0, d); chk("ovf_pend", d, 32'h02);

    // read/write collision, reserved word, unimplemented bits
    @(negedge clk);
    wren = 1'b1; rden = 1'b1; awaddr = 3'd1; araddr = 3'd1; wdata = 32'h0F;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
    chk("rw_prewrite", rdata, 32'h28);
    rd(3'd1, d); chk("rw_postwrite", d, 32'h0F);
    wr(3'd7, 32'hFFFFFFFF);
    rd(3'd7, d); chk("rsvd", d, 32'h0);
    wr(3'd1, 32'hFFFFFFFF); wr(3'd5, 32'h1);
    repeat (2) @(negedge clk);
    chk("pre_rst_irq", 32'(irq_out), 32'h1);
    rd(3'd1, d); chk("ena_width", d, 32'hFF);

    // 6: reset mid-operation with a source held high
    @(negedge clk);
    rst = 1'b1; irq_in[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_irq", 32'(irq_out), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0; wren = 1'b1; awaddr = 3'd2; wdata = 32'h01;
    @(negedge clk);
    wren = 1'b0;
    repeat (5) @(negedge clk);
    rd(3'd0, d); chk("rel_pend", d, 32'h01);
    rd(3'd2, d); chk("rel_type", d, 32'h01);
    wr(3'd0, 32'h01);
    repeat (4) @(negedge clk);
    rd(3'd0, d); chk("rel_once", d, 32'h0);
    rd(3'd4, d); chk("rel_ovf", d, 32'h0);
    irq_in = '0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
